// File: rtl/sc_bin2bcd_score_pkg.sv
// sc_score_pkg: shared FSM states, display codes and BCD helpers for the score converter
package sc_score_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  localparam logic [3:0] DASH = 4'hA;
  localparam int BCD_MAX = 9999;
  localparam int NDIG = 4;
  function automatic int bcd_val(input logic [4*NDIG-1:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
endpackage

// File: rtl/sc_bin2bcd_score_if.sv
// sc_bin2bcd_score_if: conversion request and BCD digit result bundle
interface sc_bin2bcd_score_if #(parameter int W = 14);
  logic start;
  logic [W-1:0] bin;
  logic busy;
  logic done;
  logic ovf;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  modport master(output start, bin, input busy, done, ovf, dig0, dig1, dig2, dig3);
  modport slave(input start, bin, output busy, done, ovf, dig0, dig1, dig2, dig3);
endinterface

// File: rtl/sc_bin2bcd_score_add3.sv
// sc_bcd_add3: double-dabble nibble adjust, adds 3 to any digit of 5 or more
module sc_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = din >= 4'd5 ? din + 4'd3 : din;
endmodule

// File: rtl/sc_bin2bcd_score.sv
// sc_bin2bcd_score: sequential shift-add-3 binary to four-digit BCD converter with overflow dash
module sc_bin2bcd_score
  import sc_score_pkg::*;
#(
  parameter int W = 14,
  parameter logic [3:0] DASH_CODE = DASH
) (
  input logic CC_SEVENSEG1_CLOCK_50,
  input logic CC_SEVENSEG1_RESET_InHigh,
  sc_bin2bcd_score_if.slave bus
);
  localparam int SW = 20 + W;
  localparam int CW = $clog2(W + 1);
  state_t state;
  logic [SW-1:0] sr;
  logic [SW-1:0] pre;
  logic [CW-1:0] cnt;
  logic [4:0][3:0] adj;
  logic [15:0] bcd;
  logic of;
  for (genvar g = 0; g < 5; g++) begin : g_adj
    sc_bcd_add3 u_add3 (.din(sr[W+4*g +: 4]), .dout(adj[g]));
  end
  assign pre = {adj, sr[W-1:0]};
  assign bcd = sr[W +: 16];
  // A fifth nibble catches 10000..16383; the value check also guards non-BCD nibbles
  assign of = (sr[W+16 +: 4] != 4'd0) || (bcd_val(bcd) > BCD_MAX);
  always_ff @(posedge CC_SEVENSEG1_CLOCK_50 or posedge CC_SEVENSEG1_RESET_InHigh) begin
    if (CC_SEVENSEG1_RESET_InHigh) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.dig0 <= 4'd0;
      bus.dig1 <= 4'd0;
      bus.dig2 <= 4'd0;
      bus.dig3 <= 4'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sr       <= {20'b0, bus.bin};
          cnt      <= '0;
          bus.busy <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          sr    <= {pre[SW-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          state <= cnt == CW'(W - 1) ? FINISH : SHIFT;
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.ovf  <= of;
          bus.dig0 <= of ? DASH_CODE : bcd[3:0];
          bus.dig1 <= of ? DASH_CODE : bcd[7:4];
          bus.dig2 <= of ? DASH_CODE : bcd[11:8];
          bus.dig3 <= of ? DASH_CODE : bcd[15:12];
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
